sample_packer: RTL and testbench

- Sits directly downstream of the asynchronous sample FIFO in the read (Clk) domain.
- That FIFO pops one entry on every Clk edge while EMPTY is low, and has no read-enable. This block must therefore absorb one sample per cycle with no backpressure into the FIFO.
- Packs PACK_N consecutive samples into one wide word, marks frame boundaries every FRAME_WORDS words, and presents words on a valid/ready stream toward the PS/DMA side.
- A 2-entry output queue absorbs short stalls. A word with no queue space is dropped and accounted for.

---
 rtl/sample_packer_pkg.sv | 20 ++
 rtl/packer_out_queue.sv | 54 +++++
 rtl/sample_packer.sv | 104 ++++++++++
 tb/tb_sample_packer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_packer_pkg.sv
// Shared defaults for the sample packer: sample width, packing ratio,
// frame length, drop counter width and the lane slice helper.
`ifndef SAMPLE_PACKER_LANE
`define SAMPLE_PACKER_LANE(k, w) ((k) * (w)) +: (w)
`endif

package sample_packer_pkg;

    localparam int SAMPLE_BITS     = 16;
    localparam int DEF_DATA_W      = SAMPLE_BITS;
    localparam int DEF_PACK_N      = 4;
    localparam int DEF_FRAME_WORDS = 8;
    localparam int DEF_CNT_W       = 16;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/packer_out_queue.sv
// Two-entry synchronous FIFO carrying {last, word} toward the stream sink.
// A push is taken when there is room or when a pop frees a slot in the same cycle.
module packer_out_queue #(
    parameter int W = 65
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // When full, wr_ptr equals rd_ptr; a simultaneous pop hands the head slot to the new tail.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/sample_packer.sv
// Packs PACK_N FIFO samples (one per Clk while EMPTY is low) into a wide word,
// flags frame ends, and streams words out through a two-entry queue.
module sample_packer
    import sample_packer_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int PACK_N      = DEF_PACK_N,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [DATA_W-1:0]        dataIn,
    input  logic                     EMPTY,
    output logic [DATA_W*PACK_N-1:0] outData,
    output logic                     outValid,
    input  logic                     outReady,
    output logic                     outLast,
    output logic                     overflow,
    output logic [CNT_W-1:0]         dropCount,
    input  logic                     clrOverflow
);

    localparam int LANE_W = idx_width(PACK_N);
    localparam int IDX_W  = idx_width(FRAME_WORDS);
    localparam int WORD_W = DATA_W * PACK_N;
    localparam int ASM_W  = DATA_W * (PACK_N - 1);

    logic [LANE_W-1:0] lane_cnt;
    logic [IDX_W-1:0]  word_idx;
    logic [ASM_W-1:0]  asm_q;
    logic              sample_ok;
    logic              word_done;
    logic              word_last;
    logic [WORD_W-1:0] full_word;
    logic              q_full;
    logic              q_empty;
    logic              q_push;
    logic              q_pop;
    logic              drop;

    assign sample_ok = !EMPTY;
    assign word_done = sample_ok && (lane_cnt == LANE_W'(PACK_N - 1));
    assign word_last = (word_idx == IDX_W'(FRAME_WORDS - 1));
    assign full_word = {dataIn, asm_q};

    // Stream handshake: a word transfers on any Clk edge where outValid and
    // outReady are both high; outValid never drops and the word never changes
    // until that transfer happens.
    assign q_pop  = outValid && outReady;
    assign drop   = word_done && q_full && !outReady;
    assign q_push = word_done && !drop;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            lane_cnt <= '0;
            word_idx <= '0;
            asm_q    <= '0;
        end else if (sample_ok) begin
            lane_cnt <= lane_cnt + LANE_W'(1);
            if (!word_done) begin
                asm_q[`SAMPLE_PACKER_LANE(lane_cnt, DATA_W)] <= dataIn;
            end
            // Frame position advances for dropped words too, keeping alignment with the stream.
            if (word_done) begin
                word_idx <= word_last ? '0 : word_idx + IDX_W'(1);
            end
        end
    end

    // A drop in the same cycle as a clear leaves exactly one drop recorded.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            overflow  <= 1'b0;
            dropCount <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clrOverflow) begin
                dropCount <= CNT_W'(1);
            end else if (dropCount != {CNT_W{1'b1}}) begin
                dropCount <= dropCount + CNT_W'(1);
            end
        end else if (clrOverflow) begin
            overflow  <= 1'b0;
            dropCount <= '0;
        end
    end

    packer_out_queue #(
        .W (WORD_W + 1)
    ) u_queue (
        .Clk       (Clk),
        .Rst       (Rst),
        .push      (q_push),
        .push_data ({word_last, full_word}),
        .pop       (q_pop),
        .pop_data  ({outLast, outData}),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign outValid = !q_empty;

endmodule

// File: tb/tb_sample_packer.sv
// Directed bench for sample_packer: stimulus pushes hand-computed words into
// exp_q, a negedge monitor pops and compares every accepted output word.
module tb_sample_packer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [15:0] dataIn = '0;
    logic        EMPTY = 1'b1;
    logic [63:0] outData;
    logic        outValid;
    logic        outReady = 1'b0;
    logic        outLast;
    logic        overflow;
    logic [15:0] dropCount;
    logic        clrOverflow = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic [64:0] exp_q[$];
    logic [64:0] mon_exp;
    logic        prev_stall = 1'b0;
    logic [64:0] prev_word = '0;

    sample_packer dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .dataIn      (dataIn),
        .EMPTY       (EMPTY),
        .outData     (outData),
        .outValid    (outValid),
        .outReady    (outReady),
        .outLast     (outLast),
        .overflow    (overflow),
        .dropCount   (dropCount),
        .clrOverflow (clrOverflow)
    );

    // Clock and watchdog
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [64:0] mkw(input logic last, input logic [15:0] l3,
                                        input logic [15:0] l2, input logic [15:0] l1,
                                        input logic [15:0] l0);
        return {last, l3, l2, l1, l0};
    endfunction

    // Driver tasks: inputs change 2 time units after a rising edge
    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    task automatic send(input logic [15:0] d);
        step();
        EMPTY  = 1'b0;
        dataIn = d;
    endtask

    task automatic idle();
        step();
        EMPTY       = 1'b1;
        clrOverflow = 1'b0;
    endtask

    task automatic do_reset();
        step();
        Rst         = 1'b0;
        EMPTY       = 1'b1;
        outReady    = 1'b0;
        clrOverflow = 1'b0;
        exp_q.delete();
        repeat (2) step();
        Rst = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk(name, 65'(exp_q.size()), 65'd0);
    endtask

    // Monitor / scoreboard
    always @(negedge Clk) begin
        if (!Rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 65'(outValid), 65'd1);
                chk("hold_word", {outLast, outData}, prev_word);
            end
            if (outValid && outReady) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%h required=none", {outLast, outData});
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("word", {outLast, outData}, mon_exp);
                end
            end
            prev_stall = outValid && !outReady;
            prev_word  = {outLast, outData};
        end
    end

    initial begin
        // Reset state
        #1;
        chk("rst_valid", 65'(outValid), 65'd0);
        chk("rst_last", 65'(outLast), 65'd0);
        chk("rst_data", 65'(outData), 65'd0);
        chk("rst_overflow", 65'(overflow), 65'd0);
        chk("rst_dropcount", 65'(dropCount), 65'd0);

        // Basic pack with 1-cycle latency
        do_reset();
        outReady = 1'b1;
        exp_q.push_back(mkw(1'b0, 16'h0004, 16'h0003, 16'h0002, 16'h0001));
        send(16'h0001);
        send(16'h0002);
        send(16'h0003);
        send(16'h0004);
        chk("basic_not_early", 65'(outValid), 65'd0);
        idle();
        chk("basic_valid", 65'(outValid), 65'd1);
        chk("basic_data", 65'(outData), 65'h0004_0003_0002_0001);
        wait_drain("basic_drain");

        // Frame marking over 9 words
        do_reset();
        outReady = 1'b1;
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back(mkw(k == 7, 16'(4*k+4), 16'(4*k+3), 16'(4*k+2), 16'(4*k+1)));
        end
        for (int i = 1; i <= 36; i++) send(16'(i));
        idle();
        wait_drain("frame_drain");
        chk("frame_overflow", 65'(overflow), 65'd0);

        // Gapped input
        do_reset();
        outReady = 1'b1;
        exp_q.push_back(mkw(1'b0, 16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0));
        exp_q.push_back(mkw(1'b0, 16'h00A7, 16'h00A6, 16'h00A5, 16'h00A4));
        for (int i = 0; i < 8; i++) begin
            send(16'(16'hA0 + i));
            idle();
        end
        wait_drain("gap_drain");
        chk("gap_dropcount", 65'(dropCount), 65'd0);

        // Backpressure with a drop
        do_reset();
        exp_q.push_back(mkw(1'b0, 16'h0103, 16'h0102, 16'h0101, 16'h0100));
        exp_q.push_back(mkw(1'b0, 16'h0107, 16'h0106, 16'h0105, 16'h0104));
        for (int i = 0; i < 12; i++) send(16'(16'h100 + i));
        idle();
        chk("drop_overflow", 65'(overflow), 65'd1);
        chk("drop_count", 65'(dropCount), 65'd1);
        chk("drop_valid", 65'(outValid), 65'd1);
        chk("drop_head", {outLast, outData}, mkw(1'b0, 16'h0103, 16'h0102, 16'h0101, 16'h0100));
        repeat (3) step();
        chk("drop_head_held", 65'(outData), 65'h0103_0102_0101_0100);
        outReady = 1'b1;
        wait_drain("drop_drain");

        // Full queue with simultaneous pop: no drop
        do_reset();
        exp_q.push_back(mkw(1'b0, 16'h0004, 16'h0003, 16'h0002, 16'h0001));
        exp_q.push_back(mkw(1'b0, 16'h0008, 16'h0007, 16'h0006, 16'h0005));
        exp_q.push_back(mkw(1'b0, 16'h000C, 16'h000B, 16'h000A, 16'h0009));
        for (int i = 1; i <= 11; i++) send(16'(i));
        step();
        EMPTY    = 1'b0;
        dataIn   = 16'h000C;
        outReady = 1'b1;
        idle();
        wait_drain("fullpop_drain");
        chk("fullpop_overflow", 65'(overflow), 65'd0);
        chk("fullpop_count", 65'(dropCount), 65'd0);

        // Two drops, then a clear colliding with a third drop
        outReady = 1'b0;
        for (int i = 0; i < 16; i++) send(16'(16'h40 + i));
        idle();
        chk("drop2_count", 65'(dropCount), 65'd2);
        chk("drop2_overflow", 65'(overflow), 65'd1);
        send(16'h0050);
        send(16'h0051);
        send(16'h0052);
        send(16'h0053);
        clrOverflow = 1'b1;
        idle();
        chk("clrdrop_overflow", 65'(overflow), 65'd1);
        chk("clrdrop_count", 65'(dropCount), 65'd1);
        clrOverflow = 1'b1;
        step();
        clrOverflow = 1'b0;
        chk("clr_overflow", 65'(overflow), 65'd0);
        chk("clr_count", 65'(dropCount), 65'd0);
        exp_q.push_back(mkw(1'b0, 16'h0043, 16'h0042, 16'h0041, 16'h0040));
        exp_q.push_back(mkw(1'b0, 16'h0047, 16'h0046, 16'h0045, 16'h0044));
        outReady = 1'b1;
        wait_drain("clr_drain");

        // Asynchronous reset mid-word
        do_reset();
        send(16'h0021);
        send(16'h0022);
        send(16'h0023);
        send(16'h0024);
        send(16'h0031);
        send(16'h0032);
        idle();
        chk("pre_rst_valid", 65'(outValid), 65'd1);
        #2;
        Rst = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_valid", 65'(outValid), 65'd0);
        chk("async_rst_data", 65'(outData), 65'd0);
        repeat (2) step();
        Rst      = 1'b1;
        outReady = 1'b1;
        exp_q.push_back(mkw(1'b0, 16'h0014, 16'h0013, 16'h0012, 16'h0011));
        send(16'h0011);
        send(16'h0012);
        send(16'h0013);
        send(16'h0014);
        idle();
        wait_drain("rst_restart_drain");

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
